// File: rtl/integrator_seq_pkg.sv
// integrator_seq_pkg: shared constants and FSM state encoding for the
// moving-window integrator sequencer.
//   NBIT_DEF   - default sample/sum width
//   NI_DEF     - default integrator delay-line depth (window = NI+1 samples)
//   TO_CYC_DEF - default lead-off timeout in clk cycles
//   state_t    - sequencer states (IDLE=0, CLEAR=1, FILL=2, RUN=3, DRAIN=4)
package integrator_seq_pkg;
    localparam int NBIT_DEF   = 16;
    localparam int NI_DEF     = 8;
    localparam int TO_CYC_DEF = 2000000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FILL  = 3'd2,
        RUN   = 3'd3,
        DRAIN = 3'd4
    } state_t;
endpackage

// File: rtl/integrator_seq_if.sv
// integrator_seq_if: valid/ready sample stream.
//   valid - source has data
//   ready - sink can take data
//   data  - NBIT-wide payload
// Modports: master (source side), slave (sink side).
interface integrator_seq_if #(
    parameter int NBIT = 16
) ();
    logic            valid;
    logic            ready;
    logic [NBIT-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/integrator_seq_obuf.sv
// integrator_seq_obuf: one-entry valid/ready output register holding the
// latest window sum for the peak-detector stage.
//   clk, rst - clock, synchronous active-high reset
//   flush    - drop any pending entry (lead-off recovery)
//   push     - load din; wins over a same-cycle pop so valid stays high
//   din      - value to load
//   ready    - downstream ready (pop when valid & ready)
//   valid    - entry pending
//   dout     - pending value, held while valid & !ready
module integrator_seq_obuf
    import integrator_seq_pkg::*;
#(
    parameter int NBIT = NBIT_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            push,
    input  logic [NBIT-1:0] din,
    input  logic            ready,
    output logic            valid,
    output logic [NBIT-1:0] dout
);
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (push) begin
            valid <= 1'b1;
            dout  <= din;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/integrator_seq.sv
// integrator_seq: sequencer for the moving-window integrator of the QRS
// detection chain. Accepts squared-derivative samples, drives the
// integrator's advance/clear, suppresses output until the window is full,
// and buffers each window sum toward the peak detector.
//   clk, rst    - clock, synchronous active-high reset
//   start, stop - session control pulses (stop wins in IDLE)
//   s           - upstream sample stream (slave)
//   integ_din   - integrator input (copy of s.data)
//   integ_adv   - integrator shift enable (= accept)
//   integ_clr   - integrator clear (high in CLEAR)
//   integ_sum   - integrator window sum (din + NI taps)
//   m           - window-sum stream toward the peak detector (master)
//   busy        - state != IDLE
//   fill_cnt    - samples in the delay line, saturates at NI
//   timeout_err - sticky lead-off flag
// Optional build macro INTEGRATOR_SEQ_TIMEOUT_EN enables the lead-off
// timeout; without it timeout_err is tied low.
module integrator_seq
    import integrator_seq_pkg::*;
#(
    parameter int NBIT   = NBIT_DEF,
    parameter int NI     = NI_DEF,
    parameter int TO_CYC = TO_CYC_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     stop,
    integrator_seq_if.slave          s,
    output logic [NBIT-1:0]          integ_din,
    output logic                     integ_adv,
    output logic                     integ_clr,
    input  logic [NBIT-1:0]          integ_sum,
    integrator_seq_if.master         m,
    output logic                     busy,
    output logic [$clog2(NI+1)-1:0]  fill_cnt,
    output logic                     timeout_err
);
    localparam int FW = $clog2(NI+1);

    state_t state, state_n, stop_tgt;
    logic   rdy, accept, push, to_evt;

    assign accept    = s.valid & rdy;
    assign push      = accept & (state == RUN);
    assign s.ready   = rdy;
    assign integ_din = s.data;
    assign integ_adv = accept;
    assign integ_clr = (state == CLEAR);
    assign busy      = (state != IDLE);

    // A same-cycle RUN accept will leave an entry pending, so it must drain too.
    assign stop_tgt = (m.valid || push) ? DRAIN : IDLE;

    always_comb begin
        rdy = 1'b0;
        case (state)
            FILL:    rdy = 1'b1;
            RUN:     rdy = !m.valid || m.ready;
            default: rdy = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:  if (start && !stop) state_n = CLEAR;
            CLEAR: state_n = stop ? stop_tgt : FILL;
            FILL: begin
                if (stop)                                  state_n = stop_tgt;
                else if (to_evt)                           state_n = CLEAR;
                else if (accept && fill_cnt == FW'(NI-1))  state_n = RUN;
            end
            RUN: begin
                if (stop)        state_n = stop_tgt;
                else if (to_evt) state_n = CLEAR;
            end
            DRAIN: if (!m.valid) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            fill_cnt <= '0;
        else if (state == CLEAR)
            fill_cnt <= '0;
        else if (state == FILL && accept && fill_cnt != FW'(NI))
            fill_cnt <= fill_cnt + 1'b1;
    end

`ifdef INTEGRATOR_SEQ_TIMEOUT_EN
    localparam int TW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;

    logic [TW-1:0] idle_cnt;
    logic          run_ph;

    assign run_ph = (state == FILL) || (state == RUN);
    // stop takes precedence: the session is ending anyway.
    assign to_evt = run_ph && !accept && !stop && (idle_cnt == TW'(TO_CYC-1));

    always_ff @(posedge clk) begin
        if (rst || !run_ph || accept || to_evt) idle_cnt <= '0;
        else                                    idle_cnt <= idle_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)                                   timeout_err <= 1'b0;
        else if (state == IDLE && start && !stop)  timeout_err <= 1'b0;
        else if (to_evt)                           timeout_err <= 1'b1;
    end
`else
    logic unused_to;
    assign unused_to   = (TO_CYC > 0);
    assign to_evt      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    integrator_seq_obuf #(.NBIT(NBIT)) u_obuf (
        .clk   (clk),
        .rst   (rst),
        .flush (to_evt),
        .push  (push),
        .din   (integ_sum),
        .ready (m.ready),
        .valid (m.valid),
        .dout  (m.data)
    );
endmodule
